// File: rtl/mnist_frame_driver_if.sv
// Handshake bundle between a frame source/controller and the MNIST frame driver.
// The master side feeds pixels, control and logits; the slave side is the driver.
interface mnist_frame_driver_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 32
);
  logic                    load_valid;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    load_ready;
  logic                    load_restart;
  logic                    start;
  logic                    net_ready;
  logic                    valid_out;
  logic [DATA_WIDTH-1:0]   pixel_out;
  logic                    result_valid;
  logic [RESULT_WIDTH-1:0] result_in;
  logic [3:0]              pred;
  logic [RESULT_WIDTH-1:0] pred_max;
  logic                    pred_valid;
  logic                    busy;
  logic                    timeout_err;

  modport master (
    output load_valid, load_data, load_restart, start, net_ready,
           result_valid, result_in,
    input  load_ready, valid_out, pixel_out, pred, pred_max, pred_valid,
           busy, timeout_err
  );

  modport slave (
    input  load_valid, load_data, load_restart, start, net_ready,
           result_valid, result_in,
    output load_ready, valid_out, pixel_out, pred, pred_max, pred_valid,
           busy, timeout_err
  );
endinterface

// File: rtl/mnist_frame_driver.sv
// Buffers one image frame, streams it to the network on request and reduces
// the returned logits to an argmax prediction, with a result-wait timeout.
module mnist_frame_driver #(
  parameter int IMG_PIXELS     = 784,
  parameter int DATA_WIDTH     = 8,
  parameter int OUT_CLASSES    = 10,
  parameter int RESULT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mnist_frame_driver_if.slave  bus
);

  localparam int PTR_W = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
  localparam int CNT_W = $clog2(OUT_CLASSES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PTR_W-1:0] LAST_PIX  = PTR_W'(IMG_PIXELS - 1);
  localparam logic [CNT_W-1:0] LAST_RES  = CNT_W'(OUT_CLASSES - 1);
  localparam logic [CNT_W-1:0] FULL_RES  = CNT_W'(OUT_CLASSES);
  localparam logic [TMO_W-1:0] LAST_WAIT = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RES,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0]   frame_buf [IMG_PIXELS];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    frame_loaded;
  logic [CNT_W-1:0]        res_cnt;
  logic [TMO_W-1:0]        wait_cnt;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   pixel_q;
  logic [3:0]              pred_q;
  logic [RESULT_WIDTH-1:0] pred_max_q;
  logic                    timeout_q;

  logic in_idle;
  logic start_ok;
  logic restart;
  logic load_beat;
  logic result_take;
  logic results_done;
  logic last_read;
  logic timeout_hit;

  // Restart beats a simultaneous load; a full frame blocks further loads.
  always_comb begin
    in_idle      = (state == IDLE);
    start_ok     = in_idle && bus.start && frame_loaded && bus.net_ready;
    restart      = in_idle && bus.load_restart;
    load_beat    = in_idle && !frame_loaded && bus.load_valid && !bus.load_restart;
    result_take  = ((state == STREAM) || (state == WAIT_RES)) && bus.result_valid
                   && (res_cnt != FULL_RES);
    results_done = (res_cnt == FULL_RES) || (result_take && (res_cnt == LAST_RES));
    last_read    = (state == STREAM) && (rd_ptr == LAST_PIX);
    timeout_hit  = (state == WAIT_RES) && !results_done && (wait_cnt == LAST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Results that complete during the stream are honoured once WAIT_RES is reached.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start_ok) state_next = STREAM;
      STREAM:   if (last_read) state_next = WAIT_RES;
      WAIT_RES: begin
        if (results_done) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      frame_loaded <= 1'b0;
    end else if (restart) begin
      wr_ptr       <= '0;
      frame_loaded <= 1'b0;
    end else if (load_beat) begin
      wr_ptr <= (wr_ptr == LAST_PIX) ? '0 : wr_ptr + 1'b1;
      if (wr_ptr == LAST_PIX) begin
        frame_loaded <= 1'b1;
      end
    end
  end

  // Frame storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (load_beat) begin
      frame_buf[wr_ptr] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      valid_q <= 1'b0;
      pixel_q <= '0;
    end else if (state == STREAM) begin
      valid_q <= 1'b1;
      pixel_q <= frame_buf[rd_ptr];
      rd_ptr  <= last_read ? '0 : rd_ptr + 1'b1;
    end else begin
      rd_ptr  <= '0;
      valid_q <= 1'b0;
      pixel_q <= '0;
    end
  end

  // Strictly-greater replacement keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_cnt    <= '0;
      wait_cnt   <= '0;
      pred_q     <= '0;
      pred_max_q <= '0;
      timeout_q  <= 1'b0;
    end else if (start_ok) begin
      res_cnt    <= '0;
      wait_cnt   <= '0;
      pred_q     <= '0;
      pred_max_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (result_take) begin
        res_cnt <= res_cnt + 1'b1;
        if (res_cnt == '0) begin
          pred_q     <= '0;
          pred_max_q <= bus.result_in;
        end else if ($signed(bus.result_in) > $signed(pred_max_q)) begin
          pred_q     <= 4'(res_cnt);
          pred_max_q <= bus.result_in;
        end
      end
      if (state == WAIT_RES) begin
        if (timeout_hit) begin
          timeout_q <= 1'b1;
        end
        if (wait_cnt != LAST_WAIT) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.load_ready  = in_idle && !frame_loaded;
  assign bus.valid_out   = valid_q;
  assign bus.pixel_out   = pixel_q;
  assign bus.pred        = pred_q;
  assign bus.pred_max    = pred_max_q;
  assign bus.pred_valid  = (state == DONE);
  assign bus.busy        = !in_idle;
  assign bus.timeout_err = timeout_q;

endmodule
